// File: rtl/hdmi_pll_sequencer.sv
// HDMI PLL bring-up sequencer: PLL reset pulse, lock qualification, ordered domain reset release.
// Define HDMI_PLL_SEQ_STATS_EN to count RUN-state lock losses on unlock_cnt.
module hdmi_pll_sequencer #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned SER_TO_PIX_CYC   = 8,
  parameter int unsigned MAX_RETRIES      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ser_rst,
  output logic       pix_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] unlock_cnt
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPllReset = 3'd1;
  localparam logic [2:0] StWaitLock = 3'd2;
  localparam logic [2:0] StRelease  = 3'd3;
  localparam logic [2:0] StRun      = 3'd4;
  localparam logic [2:0] StFault    = 3'd5;

  localparam int unsigned CntMaxA = (RST_PULSE_CYC > SER_TO_PIX_CYC) ? RST_PULSE_CYC
                                                                     : SER_TO_PIX_CYC;
  localparam int unsigned CntMax  = (LOCK_TIMEOUT_CYC > CntMaxA) ? LOCK_TIMEOUT_CYC : CntMaxA;
  localparam int unsigned CW      = $clog2(CntMax + 1);
  localparam int unsigned SW      = $clog2(LOCK_STABLE_CYC + 1);

  logic          meta_q, locked_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    retry_q, retry_d;

  // cnt_q is the cycle count within the current state; it restarts on every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    stable_d = '0;
    retry_d  = retry_q;
    if (!enable) begin
      state_d = StIdle;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StPllReset;
        StPllReset: if (cnt_q == CW'(RST_PULSE_CYC - 1)) state_d = StWaitLock;
        StWaitLock: begin
          if (locked_s) stable_d = stable_q + 1'b1;
          // Stability completion takes priority over a coincident timeout.
          if (locked_s && stable_q == SW'(LOCK_STABLE_CYC - 1)) begin
            state_d = StRelease;
          end else if (cnt_q == CW'(LOCK_TIMEOUT_CYC - 1)) begin
            retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
            state_d = (retry_d == 4'(MAX_RETRIES)) ? StFault : StPllReset;
          end
        end
        StRelease: begin
          if (!locked_s) begin
            state_d = StPllReset;
          end else if (cnt_q == CW'(SER_TO_PIX_CYC - 1)) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun:   if (!locked_s) state_d = StPllReset;
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      locked_s <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      pll_rst  <= 1'b1;
      ser_rst  <= 1'b1;
      pix_rst  <= 1'b1;
      ready    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      meta_q   <= pll_locked;
      locked_s <= meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      // Outputs decode the next state so they line up with the state they describe.
      pll_rst  <= (state_d == StIdle) || (state_d == StPllReset) || (state_d == StFault);
      ser_rst  <= !((state_d == StRelease) || (state_d == StRun));
      pix_rst  <= (state_d != StRun);
      ready    <= (state_d == StRun);
      fault    <= (state_d == StFault);
    end
  end

  assign retry_cnt = retry_q;

`ifdef HDMI_PLL_SEQ_STATS_EN
  logic       unlock_inc;
  logic [7:0] unlock_q;

  assign unlock_inc = enable && (state_q == StRun) && !locked_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      unlock_q <= '0;
    end else if (unlock_inc && unlock_q != 8'hff) begin
      unlock_q <= unlock_q + 8'd1;
    end
  end

  assign unlock_cnt = unlock_q;
`else
  assign unlock_cnt = '0;
`endif

  a_ready_clean: assert property (@(posedge clk) disable iff (rst)
    ready |-> (!pll_rst && !ser_rst && !pix_rst));
  a_ser_first: assert property (@(posedge clk) disable iff (rst) !pix_rst |-> !ser_rst);
  a_pll_not_ready: assert property (@(posedge clk) disable iff (rst) pll_rst |-> !ready);

endmodule

// File: tb/tb_hdmi_pll_sequencer.sv
// Randomized bench for hdmi_pll_sequencer against a phase/elapsed-time reference model.
module tb_hdmi_pll_sequencer;
  localparam int unsigned RP = 4;
  localparam int unsigned LS = 8;
  localparam int unsigned LT = 32;
  localparam int unsigned SP = 3;
  localparam int unsigned MR = 3;

  localparam int PIdle  = 0;
  localparam int PReset = 1;
  localparam int PWait  = 2;
  localparam int PRel   = 3;
  localparam int PRun   = 4;
  localparam int PFault = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, ser_rst, pix_rst, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int phase = PIdle;
  int t_enter = 0;
  int streak = 0;
  int retries = 0;
  int unlocks = 0;
  int ready_seen = 0;
  int fault_seen = 0;
  bit hist[$];

  always #5 clk = ~clk;

  hdmi_pll_sequencer #(
    .RST_PULSE_CYC   (RP),
    .LOCK_STABLE_CYC (LS),
    .LOCK_TIMEOUT_CYC(LT),
    .SER_TO_PIX_CYC  (SP),
    .MAX_RETRIES     (MR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .ser_rst   (ser_rst),
    .pix_rst   (pix_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .unlock_cnt(unlock_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h phase=%0d", tag, cyc, got, exp, phase);
    end
  endtask

  // One clock edge of the intended behaviour; lock is seen two edges late.
  task automatic model_step();
    int  elapsed;
    int  nxt;
    bit  ls;
    cyc++;
    if (rst) begin
      phase   = PIdle;
      t_enter = cyc;
      streak  = 0;
      retries = 0;
      unlocks = 0;
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      return;
    end
    ls = hist.pop_front();
    hist.push_back(pll_locked);
    elapsed = cyc - t_enter;
    nxt = phase;
    if (!enable) begin
      nxt = PIdle;
      retries = 0;
    end else begin
      case (phase)
        PIdle:  nxt = PReset;
        PReset: if (elapsed == int'(RP)) nxt = PWait;
        PWait: begin
          streak = ls ? streak + 1 : 0;
          if (streak == int'(LS)) begin
            nxt = PRel;
          end else if (elapsed == int'(LT)) begin
            if (retries < 15) retries++;
            nxt = (retries == int'(MR)) ? PFault : PReset;
          end
        end
        PRel: begin
          if (!ls) nxt = PReset;
          else if (elapsed == int'(SP)) begin
            nxt = PRun;
            retries = 0;
          end
        end
        PRun: begin
          if (!ls) begin
            nxt = PReset;
            if (unlocks < 255) unlocks++;
          end
        end
        default: nxt = phase;
      endcase
    end
    if (nxt != phase) begin
      phase   = nxt;
      t_enter = cyc;
      streak  = 0;
    end
  endtask

  task automatic compare();
    int exp_unlock;
`ifdef HDMI_PLL_SEQ_STATS_EN
    exp_unlock = unlocks;
`else
    exp_unlock = 0;
`endif
    check_eq("pll_rst", 32'(pll_rst),
             (phase == PIdle || phase == PReset || phase == PFault) ? 1 : 0);
    check_eq("ser_rst", 32'(ser_rst), (phase == PRel || phase == PRun) ? 0 : 1);
    check_eq("pix_rst", 32'(pix_rst), (phase == PRun) ? 0 : 1);
    check_eq("ready", 32'(ready), (phase == PRun) ? 1 : 0);
    check_eq("fault", 32'(fault), (phase == PFault) ? 1 : 0);
    check_eq("retry_cnt", 32'(retry_cnt), retries);
    check_eq("unlock_cnt", 32'(unlock_cnt), exp_unlock);
    if (ready === 1'b1) ready_seen++;
    if (fault === 1'b1) fault_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // mode: 0 = lock low, 1 = lock high, 2 = mostly high with random drops
  task automatic run(input int n, input bit en, input int mode);
    for (int i = 0; i < n; i++) begin
      enable = en;
      if (mode == 0) pll_locked = 1'b0;
      else if (mode == 1) pll_locked = 1'b1;
      else pll_locked = ($urandom_range(0, 14) != 0);
      tick();
    end
  endtask

  initial begin
    int kind;
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int e = 0; e < 48; e++) begin
      kind = (e < 6) ? e : int'($urandom_range(0, 5));
      case (kind)
        0: begin
          run(int'($urandom_range(5, 20)), 1'b1, 0);
          run(70, 1'b1, 1);
        end
        1: run(80, 1'b1, 2);
        2: begin
          run(150, 1'b1, 0);
          run(int'($urandom_range(1, 4)), 1'b0, 0);
        end
        3: begin
          run(int'($urandom_range(5, 40)), 1'b1, 1);
          run(int'($urandom_range(1, 5)), 1'b0, 1);
        end
        4: begin
          rst = 1'b1;
          run(int'($urandom_range(1, 2)), 1'b1, 1);
          rst = 1'b0;
        end
        default: begin
          run(50, 1'b1, 1);
          run(int'($urandom_range(1, 3)), 1'b1, 0);
          run(50, 1'b1, 1);
        end
      endcase
    end
    check_eq("ready_seen", 32'(ready_seen != 0), 1);
    check_eq("fault_seen", 32'(fault_seen != 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hdmi_pll_sequencer.md
Name: hdmi_pll_sequencer

Overview:
Sequences the HDMI clock-generation PLL (ECP5 EHXPLLL, RST port enabled) and the reset release of the video domains it feeds. Pulses the PLL reset, qualifies lock with a stability window, then releases the serializer reset before the pixel reset. Lock loss triggers a clean recovery; repeated lock timeouts latch a fault. Runs on a free-running reference clock, never on a PLL output.

Parameters:
RST_PULSE_CYC, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_STABLE_CYC, 1024, consecutive synchronized-locked cycles required before lock is accepted (>=1)
LOCK_TIMEOUT_CYC, 65536, max cycles in WAIT_LOCK before the attempt counts as failed
SER_TO_PIX_CYC, 8, cycles between ser_rst release and pix_rst release (>=1)
MAX_RETRIES, 7, failed attempts before FAULT (1..15)

Ports:
clk  in  1  free-running reference clock; the only clock
rst  in  1  synchronous, active-high reset
enable  in  1  level; 1 = bring video clocks up, 0 = shut down
pll_locked  in  1  PLL LOCK output; asynchronous to clk
pll_rst  out  1  to PLL RST
ser_rst  out  1  synchronous reset for the 5x serializer domain
pix_rst  out  1  synchronous reset for the pixel domain
ready  out  1  clocks up, both domains out of reset
fault  out  1  MAX_RETRIES consecutive lock timeouts
retry_cnt  out  4  failed attempts since last RUN entry or IDLE
unlock_cnt  out  8  lock-loss events while in RUN (see Optional Feature)

Behaviour:
- The interface has one clock and its reset is synchronous, active-high: clk is the single clock; rst is synchronous and active-high.
- All outputs are registered. Values on rst: state=IDLE, pll_rst=1, ser_rst=1, pix_rst=1, ready=0, fault=0, retry_cnt=0, unlock_cnt=0.
- pll_locked passes through a 2-flop synchronizer to locked_s. That adds 2 cycles of latency, and all lock timing below is on locked_s.
- States: IDLE, PLL_RESET, WAIT_LOCK, RELEASE, RUN, FAULT.
- IDLE: pll_rst=ser_rst=pix_rst=1, ready=0. enable=1 -> PLL_RESET.
- PLL_RESET: pll_rst=1 for exactly RST_PULSE_CYC cycles. Then -> WAIT_LOCK, and pll_rst=0 on the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Stable counter increments while locked_s=1 and clears on locked_s=0.
  - When the stable counter reaches LOCK_STABLE_CYC -> RELEASE.
  - Timeout counter starts at 0 on entry. When it reaches LOCK_TIMEOUT_CYC without success, retry_cnt increments (saturates at 15).
  - If the new retry_cnt == MAX_RETRIES -> FAULT, otherwise -> PLL_RESET.
  - If stable completion and timeout coincide, success wins.
- RELEASE:
  - ser_rst=0 from the first RELEASE cycle.
  - After SER_TO_PIX_CYC cycles -> RUN, with pix_rst=0 and ready=1 on the first RUN cycle. retry_cnt clears on RUN entry.
  - locked_s=0 during RELEASE: ser_rst=1 next cycle, -> PLL_RESET. This does not count as a retry.
- RUN:
  - locked_s=0: next cycle ready=0, ser_rst=pix_rst=1, -> PLL_RESET, unlock_cnt+1 (saturating at 255). Not a retry.
- FAULT: fault=1, pll_rst=ser_rst=pix_rst=1, ready=0. Left only on enable=0 -> IDLE, which clears fault and retry_cnt.
- enable=0 in any state: next state is IDLE; all resets assert and ready=0 on the next cycle. Counters in progress are discarded.
- rst mid-operation: immediate return to the reset values above on the next edge, regardless of state.
- Invariants, checked by assertions:
  - ready=1 implies pll_rst=0, ser_rst=0 and pix_rst=0.
  - pix_rst never deasserts before ser_rst.
  - pll_rst=1 implies ready=0.

Optional Feature:
Macro HDMI_PLL_SEQ_STATS_EN.
- Defined: unlock_cnt is an 8-bit saturating counter of RUN-state lock losses, cleared only by rst.
- Undefined: no counter logic; unlock_cnt is constant 0. The port remains for a fixed interface.

Test Plan:
(Parameters for all scenarios: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, SER_TO_PIX_CYC=3, MAX_RETRIES=3.)
1. Clean bring-up: rst, then enable=1; pll_locked rises 10 cycles after pll_rst falls.
   -> pll_rst high 4 cycles; ser_rst falls 2+8 cycles after pll_locked rises; pix_rst falls and ready rises 3 cycles later; retry_cnt=0.
2. Glitchy lock: pll_locked high 5 cycles, low 1, then high steadily.
   -> stable counter restarts; ser_rst falls 8 cycles (+2 sync) after the final rise; no retry.
3. Timeouts: pll_locked held 0.
   -> 3 PLL_RESET pulses of 4 cycles spaced by 32-cycle waits; retry_cnt 1, 2, 3; fault=1 and all resets high after the third timeout. enable=0 -> fault=0, retry_cnt=0 next cycle.
4. Lock loss in RUN: drop pll_locked for 1 cycle.
   -> 2 sync cycles + 1 later: ready=0, ser_rst=pix_rst=1, pll_rst=1 for 4 cycles; full re-bring-up. unlock_cnt=1 with the macro, 0 without.
5. enable drop mid-RELEASE: enable=0 after ser_rst falls.
   -> next cycle ser_rst=pix_rst=pll_rst=1, state IDLE, ready never asserted.
6. rst asserted while in RUN -> next cycle all outputs at reset values; re-bring-up behaves as scenario 1.
